idct_transpose_buffer: RTL and testbench



---
 rtl/idct_transpose_buffer.sv | 175 +++++++++++++++++
 tb/tb_idct_transpose_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/idct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the IDCT row and column passes.
// Optional macro IDCT_TRANSPOSE_LAST_EN adds an out_last block-framing output.
module idct_transpose_buffer #(
  parameter int WIDTH = 12
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_0,
  input  logic signed [WIDTH-1:0] in_1,
  input  logic signed [WIDTH-1:0] in_2,
  input  logic signed [WIDTH-1:0] in_3,
  input  logic signed [WIDTH-1:0] in_4,
  input  logic signed [WIDTH-1:0] in_5,
  input  logic signed [WIDTH-1:0] in_6,
  input  logic signed [WIDTH-1:0] in_7,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_0,
  output logic signed [WIDTH-1:0] out_1,
  output logic signed [WIDTH-1:0] out_2,
  output logic signed [WIDTH-1:0] out_3,
  output logic signed [WIDTH-1:0] out_4,
  output logic signed [WIDTH-1:0] out_5,
  output logic signed [WIDTH-1:0] out_6,
  output logic signed [WIDTH-1:0] out_7
`ifdef IDCT_TRANSPOSE_LAST_EN
  ,
  output logic                    out_last
`endif
);

  logic signed [WIDTH-1:0] bank_r [2][8][8];
  logic signed [WIDTH-1:0] row_s [8];
  logic signed [WIDTH-1:0] col_s [8];

  logic [1:0] full_r;
  logic [1:0] full_nxt_s;
  logic       wr_bank_r;
  logic       wr_bank_nxt_s;
  logic [2:0] wr_row_r;
  logic [2:0] wr_row_nxt_s;
  logic       rd_bank_r;
  logic       rd_bank_nxt_s;
  logic [2:0] rd_col_r;
  logic [2:0] rd_col_nxt_s;

  logic in_ready_r;
  logic out_valid_r;
  logic wr_fire_s;
  logic rd_fire_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign wr_fire_s = in_valid && in_ready_r;
  assign rd_fire_s = out_valid_r && out_ready;

  // Gather the incoming row into an indexable array.
  always_comb begin
    row_s[0] = in_0;
    row_s[1] = in_1;
    row_s[2] = in_2;
    row_s[3] = in_3;
    row_s[4] = in_4;
    row_s[5] = in_5;
    row_s[6] = in_6;
    row_s[7] = in_7;
  end

  // Next-state decode for the write and read pointers and the bank flags.
  always_comb begin
    full_nxt_s    = full_r;
    wr_bank_nxt_s = wr_bank_r;
    wr_row_nxt_s  = wr_row_r;
    rd_bank_nxt_s = rd_bank_r;
    rd_col_nxt_s  = rd_col_r;
    if (wr_fire_s) begin
      wr_row_nxt_s = wr_row_r + 3'd1;
      if (wr_row_r == 3'd7) begin
        full_nxt_s[wr_bank_r] = 1'b1;
        wr_bank_nxt_s         = ~wr_bank_r;
      end else begin
        wr_bank_nxt_s = wr_bank_r;
      end
    end else begin
      wr_row_nxt_s = wr_row_r;
    end
    // A write can only target an empty bank and a read only a full one,
    // so the two flag updates never collide on the same bit.
    if (rd_fire_s) begin
      rd_col_nxt_s = rd_col_r + 3'd1;
      if (rd_col_r == 3'd7) begin
        full_nxt_s[rd_bank_r] = 1'b0;
        rd_bank_nxt_s         = ~rd_bank_r;
      end else begin
        rd_bank_nxt_s = rd_bank_r;
      end
    end else begin
      rd_col_nxt_s = rd_col_r;
    end
  end

  // Pointer, flag and handshake-output registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      full_r      <= 2'b00;
      wr_bank_r   <= 1'b0;
      wr_row_r    <= 3'd0;
      rd_bank_r   <= 1'b0;
      rd_col_r    <= 3'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      full_r      <= full_nxt_s;
      wr_bank_r   <= wr_bank_nxt_s;
      wr_row_r    <= wr_row_nxt_s;
      rd_bank_r   <= rd_bank_nxt_s;
      rd_col_r    <= rd_col_nxt_s;
      in_ready_r  <= !full_nxt_s[wr_bank_nxt_s];
      out_valid_r <= full_nxt_s[rd_bank_nxt_s];
    end
  end

  // Storage banks: one full row written per accepted handshake.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          for (int c = 0; c < 8; c++) begin
            bank_r[b][r][c] <= '0;
          end
        end
      end
    end else if (wr_fire_s) begin
      for (int c = 0; c < 8; c++) begin
        bank_r[wr_bank_r][wr_row_r][c] <= row_s[c];
      end
    end
  end

  // Column read straight from the storage flops.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      col_s[k] = bank_r[rd_bank_r][k][rd_col_r];
    end
  end

  assign out_0 = col_s[0];
  assign out_1 = col_s[1];
  assign out_2 = col_s[2];
  assign out_3 = col_s[3];
  assign out_4 = col_s[4];
  assign out_5 = col_s[5];
  assign out_6 = col_s[6];
  assign out_7 = col_s[7];

`ifdef IDCT_TRANSPOSE_LAST_EN
  logic out_last_r;

  assign out_last = out_last_r;

  // Flags the final column of a block, tracking the next read state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_last_r <= 1'b0;
    end else begin
      out_last_r <= full_nxt_s[rd_bank_nxt_s] && (rd_col_nxt_s == 3'd7);
    end
  end
`else
  // Without framing, downstream counts columns itself.
`endif

endmodule

// File: tb/tb_idct_transpose_buffer.sv
// Directed bench for idct_transpose_buffer; checks out_last when
// IDCT_TRANSPOSE_LAST_EN is defined.
module tb_idct_transpose_buffer;
  localparam int W = 12;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_n_in;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [W-1:0] in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7;
  logic signed [W-1:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6, out_7;
`ifdef IDCT_TRANSPOSE_LAST_EN
  logic out_last;
`endif

  int checks = 0;
  int errors = 0;

  idct_transpose_buffer #(.WIDTH(W)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_0(in_0), .in_1(in_1), .in_2(in_2), .in_3(in_3),
    .in_4(in_4), .in_5(in_5), .in_6(in_6), .in_7(in_7),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .out_4(out_4), .out_5(out_5), .out_6(out_6), .out_7(out_7)
`ifdef IDCT_TRANSPOSE_LAST_EN
    , .out_last(out_last)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Row r of a block with element c = base + c.
  task automatic drive_row(input int base);
    in_0 = W'(base + 0);
    in_1 = W'(base + 1);
    in_2 = W'(base + 2);
    in_3 = W'(base + 3);
    in_4 = W'(base + 4);
    in_5 = W'(base + 5);
    in_6 = W'(base + 6);
    in_7 = W'(base + 7);
  endtask

  // Expect column j of a block whose element (r,c) = base + 8r + c.
  task automatic chk_col(input string tag, input int base, input int j, input int last_exp);
    int o[8];
    o[0] = out_0; o[1] = out_1; o[2] = out_2; o[3] = out_3;
    o[4] = out_4; o[5] = out_5; o[6] = out_6; o[7] = out_7;
    chk($sformatf("%s_c%0d_valid", tag, j), int'(out_valid), 1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_c%0d_out%0d", tag, j, k), o[k], base + 8 * k + j);
    end
`ifdef IDCT_TRANSPOSE_LAST_EN
    chk($sformatf("%s_c%0d_last", tag, j), int'(out_last), last_exp);
`else
    if (last_exp > 1) $display("unexpected last flag %0d", last_exp);
`endif
  endtask

  task automatic do_reset();
    rst_n_in  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_row(0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
  endtask

  initial begin
    rst_n_in  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_row(0);
    @(negedge clk_in);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out0", int'(out_0), 0);
    chk("rst_out7", int'(out_7), 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Single block, element = 8r + c.
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      drive_row(8 * r);
      in_valid = 1'b1;
      chk($sformatf("t1_in_ready_r%0d", r), int'(in_ready), 1);
      chk($sformatf("t1_no_valid_r%0d", r), int'(out_valid), 0);
      @(negedge clk_in);
    end
    in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk_col("t1", 0, j, (j == 7) ? 1 : 0);
      @(negedge clk_in);
    end
    chk("t1_done_valid", int'(out_valid), 0);

    // Four back-to-back blocks, element = 64n + 8r + c - 2048.
    for (int t = 0; t < 40; t++) begin
      if (t < 32) begin
        drive_row(64 * (t / 8) + 8 * (t % 8) - 2048);
        in_valid = 1'b1;
        chk($sformatf("t2_in_ready_t%0d", t), int'(in_ready), 1);
      end else begin
        in_valid = 1'b0;
      end
      if (t >= 8) begin
        chk_col($sformatf("t2_b%0d", (t - 8) / 8), 64 * ((t - 8) / 8) - 2048,
                (t - 8) % 8, (((t - 8) % 8) == 7) ? 1 : 0);
      end else begin
        chk($sformatf("t2_no_valid_t%0d", t), int'(out_valid), 0);
      end
      @(negedge clk_in);
    end
    chk("t2_done_valid", int'(out_valid), 0);

    // Backpressure: two full blocks, a 17th row must be refused.
    do_reset();
    for (int t = 0; t < 16; t++) begin
      drive_row(64 * (t / 8) + 8 * (t % 8));
      in_valid = 1'b1;
      chk($sformatf("t3_in_ready_t%0d", t), int'(in_ready), 1);
      @(negedge clk_in);
    end
    drive_row(900);
    chk("t3_full_in_ready", int'(in_ready), 0);
    chk("t3_full_valid", int'(out_valid), 1);
    @(negedge clk_in);
    chk("t3_full_in_ready2", int'(in_ready), 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk_col("t3_b0", 0, j, (j == 7) ? 1 : 0);
      chk($sformatf("t3_drain_in_ready_c%0d", j), int'(in_ready), 0);
      @(negedge clk_in);
    end
    chk("t3_freed_in_ready", int'(in_ready), 1);
    for (int j = 0; j < 8; j++) begin
      chk_col("t3_b1", 64, j, (j == 7) ? 1 : 0);
      @(negedge clk_in);
    end
    chk("t3_done_valid", int'(out_valid), 0);

    // Output stall at column 3.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      drive_row(200 + 8 * r);
      in_valid = 1'b1;
      @(negedge clk_in);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk_col("t4", 200, j, 0);
      @(negedge clk_in);
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk_col($sformatf("t4_stall%0d", s), 200, 3, 0);
      @(negedge clk_in);
    end
    out_ready = 1'b1;
    for (int j = 3; j < 8; j++) begin
      chk_col("t4", 200, j, (j == 7) ? 1 : 0);
      @(negedge clk_in);
    end
    chk("t4_done_valid", int'(out_valid), 0);

    // Reset after 5 rows of a block, then a clean block.
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      drive_row(300 + 8 * r);
      in_valid = 1'b1;
      @(negedge clk_in);
    end
    in_valid = 1'b0;
    chk("t5_pre_out0", int'(out_0), 300);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("t5_rst_in_ready", int'(in_ready), 1);
    chk("t5_rst_out_valid", int'(out_valid), 0);
    chk("t5_rst_out0", int'(out_0), 0);
    chk("t5_rst_out4", int'(out_4), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      drive_row(400 + 8 * r);
      in_valid = 1'b1;
      chk($sformatf("t5_in_ready_r%0d", r), int'(in_ready), 1);
      @(negedge clk_in);
    end
    in_valid = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk_col("t5", 400, j, (j == 7) ? 1 : 0);
      @(negedge clk_in);
    end
    chk("t5_done_valid", int'(out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
